// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer memory, redirect and decode handshake bundle
interface fetch_sequencer_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_next;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  branch_taken,
        input  branch_addr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_next
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output branch_taken,
        output branch_addr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_next
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller with prefetch FIFO and branch redirect
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter int          DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    fetch_sequencer_if.master    bus,
    output logic                 err,
    output logic                 running,
    output logic [31:0]          instr_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        ERROR = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fpc_q, fpc_d;
    logic            err_q, err_d;
    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     pc_q    [DEPTH];
    logic [31:0]     pcn_q   [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     instr_count_q;
    logic            head_valid;
    logic            fire;
    logic            pop;
    logic            flush;

    assign head_valid = (count_q != '0);
    assign pop        = head_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        err_d   = err_q;
        fire    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                // A redirect suppresses the fetch; the memory word at fpc belongs to the dead path.
                if (bus.branch_taken) begin
                    flush = 1'b1;
                    if (bus.branch_addr[1:0] != 2'b00) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        fpc_d = bus.branch_addr;
                    end
                end else if ((count_q < DEPTH_C) || pop) begin
                    fire  = 1'b1;
                    fpc_d = fpc_q + PC_STEP;
                end
            end
            ERROR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({fire, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q         <= RESET_PC;
            err_q         <= 1'b0;
            count_q       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            instr_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                pcn_q[i]   <= RESET_PC + PC_STEP;
            end
        end else begin
            fpc_q <= fpc_d;
            err_q <= err_d;
            if (pop) instr_count_q <= instr_count_q + 32'd1;
            if (flush) begin
                count_q <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
            end else begin
                if (fire) begin
                    instr_q[wr_ptr] <= bus.imem_rdata;
                    pc_q[wr_ptr]    <= fpc_q;
                    pcn_q[wr_ptr]   <= fpc_q + PC_STEP;
                    wr_ptr          <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count_q <= count_d;
            end
        end
    end

    assign bus.imem_addr   = fpc_q;
    assign bus.out_valid   = head_valid;
    assign bus.out_instr   = instr_q[rd_ptr];
    assign bus.out_pc      = pc_q[rd_ptr];
    assign bus.out_pc_next = pcn_q[rd_ptr];
    assign err             = err_q;
    assign running         = (state_q == RUN);
    assign instr_count     = instr_count_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the combinational instruction memory for the processor's IF stage. Owns the fetch PC and drives the memory address, captures each returned word together with its PC into a small prefetch FIFO, and hands instructions to decode over a valid/ready handshake. Handles branch redirects (flush and refetch), start-up gating, and a sticky misaligned-branch error state, and keeps a count of delivered instructions.

## Interface
- RESET_PC, 32'd0, fetch address after reset
- PC_STEP, 4, byte increment per sequential fetch
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; leaves IDLE
- imem_addr  output  32  address to instruction memory (`pc` input)
- imem_rdata  input  32  instruction word, combinationally valid same cycle as imem_addr
- branch_taken  input  1  redirect request from execute
- branch_addr  input  32  redirect target, sampled when branch_taken=1
- out_valid  output  1  FIFO head holds an instruction
- out_ready  input  1  decode accepts head this cycle
- out_instr  output  32  instruction at FIFO head
- out_pc  output  32  address of out_instr
- out_pc_next  output  32  out_pc + PC_STEP
- err  output  1  sticky: misaligned branch target
- running  output  1  state == RUN
- instr_count  output  32  number of completed out handshakes

## Operation
- States: IDLE, RUN, ERROR (two-bit encoding; state register reset to IDLE).
- IDLE: no fetch, FIFO empty; start=1 -> RUN next cycle. branch_taken ignored.
- RUN: fetch condition fire = !branch_taken && (count < DEPTH || (out_valid && out_ready)). On fire: push {fpc, imem_rdata}, fpc <= fpc + PC_STEP (32-bit wrap, 0xFFFFFFFC + 4 = 0).
- Pop: out_valid && out_ready removes head; instr_count += 1 (32-bit wrap). Push and pop in the same cycle leave count unchanged.
- Redirect (RUN, branch_taken=1, branch_addr[1:0]==0): FIFO flushed (count <= 0), fpc <= branch_addr, no push that cycle. A handshake completing in the same cycle still counts (instr_count increments).
- Misaligned (RUN, branch_taken=1, branch_addr[1:0]!=0): -> ERROR, FIFO flushed, err <= 1, fpc unchanged.
- ERROR: no fetch, out_valid=0, err held at 1; exits only via rst. start ignored.
- imem_addr = fpc combinationally in all states.
- out_instr/out_pc/out_pc_next reflect FIFO head; hold last values when empty (don't-care for the checker only when out_valid=0).

## Timing
- Reset values: state IDLE, fpc=RESET_PC, imem_addr=RESET_PC, FIFO count 0, out_valid 0, out_instr 0, out_pc 0, out_pc_next RESET_PC+PC_STEP, err 0, running 0, instr_count 0.
- rst has priority over every other input, including mid-redirect and in ERROR.
- start at cycle N -> running=1 at N+1, first push at N+1, out_valid=1 at N+2 with out_pc=RESET_PC.
- Steady state with out_ready held 1: one instruction per cycle, no bubbles.
- out_ready=0: FIFO fills to DEPTH, then fetch stalls and fpc holds; no instruction lost or duplicated. Resuming out_ready restores one/cycle immediately.
- branch_taken at cycle N -> out_valid=0 at N+1, out_valid=1 at N+2 with out_pc=branch_addr.
- branch_taken held multiple cycles: each cycle re-redirects; fetch resumes the cycle after it drops.
- Misaligned branch at N: err=1 and out_valid=0 from N+1 onward.

## Test plan
- Reset, start at cycle 2, out_ready=1: out_pc sequence 0,4,8,…,24 on consecutive cycles from cycle 4; out_instr matches memory contents per address; instr_count=7 after 7 handshakes.
- out_ready=0 for 6 cycles after start: out_valid=1, count saturates at 2, imem_addr holds 8; release -> out_pc 0,4,8,12 with no gaps or repeats.
- Branch to 0x10 while head is pc=8 and out_ready=1: pc=8 accepted (count +1), next out_valid cycle shows out_pc=0x10, out_pc_next=0x14; entries at 0xC never delivered.
- Branch to 0x12: err=1, out_valid=0, running=0 thereafter; start ignored; rst returns to IDLE with err=0.
- Branch to 0xFFFFFFFC: delivers 0xFFFFFFFC then out_pc wraps to 0x0; out_pc_next of first = 0x0.
- rst asserted during RUN with full FIFO: next cycle out_valid=0, imem_addr=RESET_PC, instr_count=0, state IDLE.
